avalon_responder: RTL and testbench
===================================

Name: avalon_responder

Overview:
- Avalon-MM slave (responder): the far end of the initiator produced by avalon_generator.
- Backed by an internal word memory; supports waitrequest flow control, pipelined reads with fixed latency and readdatavalid, and write/read bursts.
- Connects directly to the generator's bus in bench wrappers so the generator/assertion pair runs against real slave behaviour instead of a passive model.

Parameters:
- NBDATABYTES, 2, bytes per data word; data width DW = 8*NBDATABYTES.
- NBADDRBITS, 8, word-address width; memory depth 2**NBADDRBITS words.
- READLATENCY, 2, cycles from read-beat issue to readdatavalid; legal range 1..8.
- MAXBURST, 16, largest accepted burstcount; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  NBADDRBITS  word address.
- byteenable  in  NBDATABYTES  write byte lanes; bit i covers data bits 8i+7..8i.
- writedata  in  DW  write data.
- readdata  out  DW  read data, qualified by readdatavalid.
- read  in  1  read request.
- write  in  1  write request.
- waitrequest  out  1  slave stall; a command is accepted only when (read|write) and !waitrequest.
- readdatavalid  out  1  readdata valid this cycle.
- burstcount  in  8  beats in transfer; 0 is treated as 1.
- beginbursttransfer  in  1  first-beat marker; informational only, not used for control.

Behaviour:
- Reset (rst=0, asynchronous): waitrequest=1, readdatavalid=0, readdata=0, FSM=IDLE, memory cleared to 0, latency pipe flushed.
- After release: waitrequest=0 from the first clk edge.
- FSM states: IDLE, WRBURST, RDBURST.
- IDLE: waitrequest=0.
  - Accepted write with burstcount<=1: mem[address] updated on enabled byte lanes only; stay IDLE.
  - Accepted write with burstcount>1: first beat written; latch addr+1 and remaining=burstcount-1; go to WRBURST.
  - Accepted read: latch address and N=max(burstcount,1); issue the beat for address in the same cycle.
    - N=1: stay IDLE.
    - N>1: go to RDBURST with remaining=N-1.
  - read and write both high: write wins; read is dropped.
- WRBURST: waitrequest=0.
  - Each cycle with write=1 writes writedata to the internal address counter, increments it, and decrements remaining.
  - address and burstcount inputs are ignored.
  - Cycles with write=0 are idle.
  - remaining reaches 0 -> IDLE.
  - read=1 during WRBURST is ignored.
- RDBURST: waitrequest=1.
  - Issues one beat per cycle at the internal address counter, incrementing the counter.
  - remaining reaches 0 -> IDLE.
  - On the cycle after the last beat, waitrequest returns to 0.
- Read pipe: each issued beat produces readdatavalid=1 with mem[beat address] exactly READLATENCY cycles later.
  - Data is sampled at issue, so writes accepted in earlier cycles are visible; a write in the same cycle as the issue is not.
  - No readdata backpressure.
  - Back-to-back single reads give back-to-back readdatavalid.
  - readdata holds its last value while readdatavalid=0.
- Address wrap: counters wrap modulo 2**NBADDRBITS; the beat after all-ones goes to 0.
- burstcount>MAXBURST: clamped to MAXBURST.
- Reset mid-burst: aborts the burst, clears in-flight reads (no readdatavalid), forces waitrequest=1.

Optional Feature:
- AVL_RESP_RANDWAIT_EN defined:
  - A 16-bit LFSR (seed 16'hACE1, reset value) forces waitrequest=1 in IDLE/WRBURST whenever lfsr[1:0]==2'b00.
  - The LFSR advances every cycle.
  - A stalled command is not accepted and must be held by the initiator.
- Undefined: no LFSR; waitrequest is driven only by the FSM as above.

Decomposition:
- Package avalon_resp_pkg:
  - typedef enum state_t {IDLE, WRBURST, RDBURST};
  - constant LFSR_SEED;
  - function be_merge(old, new, be) for byte-lane writes.
- Sub-module avalon_resp_pipe: READLATENCY-deep valid+data shift register; inputs issue valid/data, outputs readdatavalid/readdata; own async active-low reset.

Test Plan:
- Reset then single write addr 0x10, data 16'hBEEF, be 2'b11; read 0x10 -> readdatavalid exactly 2 cycles after acceptance, readdata=16'hBEEF.
- Write 0x20=16'h1234 (be 11); write 0x20=16'hAB00 with be 2'b10; read 0x20 -> 16'hAB34.
- Write burst of 4 at 0xFE, data 1,2,3,4, with write deasserted one cycle mid-burst -> reads of 0xFE,0xFF,0x00,0x01 return 1,2,3,4 (wrap).
- Read burst of 4 at 0xFE -> waitrequest=1 for 3 cycles after acceptance; 4 consecutive readdatavalid beats carrying 1,2,3,4.
- Three back-to-back single reads of 0x10, 0x20, 0xFE -> readdatavalid high on 3 consecutive cycles with 16'hBEEF, 16'hAB34, 16'h0001.
- rst low one cycle after a burst-8 read is accepted -> no readdatavalid afterwards; waitrequest=1 during reset; read of 0x10 after release returns 0.

Source files
------------

// File: rtl/avalon_resp_pkg.sv
// rtl/avalon_resp_pkg.sv - shared types, constants and byte-lane merge helper for avalon_responder
package avalon_resp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRBURST = 2'd1,
    RDBURST = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One byte lane of a masked write: keep the old byte unless the lane is enabled
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/avalon_resp_pipe.sv
// rtl/avalon_resp_pipe.sv - fixed-latency readdatavalid/readdata shift pipe
module avalon_resp_pipe #(
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  input  logic [DW-1:0] iss_data,
  output logic          readdatavalid,
  output logic [DW-1:0] readdata
);

  logic [LAT-1:0] vld_q, vld_d;
  logic [DW-1:0]  dat_q [LAT];
  logic [DW-1:0]  dat_d [LAT];
  logic [LAT:0]   vin;
  logic [DW-1:0]  din [LAT+1];

  // Shift valid every cycle; a stage's data only loads with a valid beat so the output holds
  always_comb begin
    vin[0] = iss_valid;
    din[0] = iss_data;
    for (int i = 0; i < LAT; i++) begin
      vin[i+1] = vld_q[i];
      din[i+1] = dat_q[i];
      vld_d[i] = vin[i];
      dat_d[i] = vin[i] ? din[i] : dat_q[i];
    end
  end

  assign readdatavalid = vin[LAT];
  assign readdata      = din[LAT];

  // Pipe registers; reset flushes any beats in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/avalon_responder.sv
// rtl/avalon_responder.sv - Avalon-MM memory responder with bursts; AVL_RESP_RANDWAIT_EN adds LFSR random waitrequest
module avalon_responder
  import avalon_resp_pkg::*;
#(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int READLATENCY = 2,
  parameter int MAXBURST    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBADDRBITS-1:0]    address,
  input  logic [NBDATABYTES-1:0]   byteenable,
  input  logic [8*NBDATABYTES-1:0] writedata,
  output logic [8*NBDATABYTES-1:0] readdata,
  input  logic                     read,
  input  logic                     write,
  output logic                     waitrequest,
  output logic                     readdatavalid,
  input  logic [7:0]               burstcount,
  input  logic                     beginbursttransfer
);

  localparam int DW    = 8 * NBDATABYTES;
  localparam int DEPTH = 2 ** NBADDRBITS;
  localparam logic [NBADDRBITS-1:0] ADDR_ONE = 1;

  state_t                state_q, state_d;
  logic [NBADDRBITS-1:0] addr_q, addr_d;
  logic [7:0]            rem_q, rem_d;
  logic                  started_q, started_d;
  logic [DW-1:0]         mem_q [DEPTH];

  logic                  stall;
  logic [7:0]            n_beats;
  logic                  wr_en;
  logic [NBADDRBITS-1:0] wr_addr;
  logic [DW-1:0]         wr_word;
  logic                  iss_v;
  logic [NBADDRBITS-1:0] iss_addr;
  logic                  unused_bbt;

  assign unused_bbt = beginbursttransfer;

`ifdef AVL_RESP_RANDWAIT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Free-running Fibonacci LFSR (taps 16,14,13,11)
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // LFSR register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // burstcount 0 means a single beat; oversize bursts are clamped
  always_comb begin
    n_beats = burstcount;
    if (burstcount == 8'd0)                n_beats = 8'd1;
    else if (burstcount > 8'(MAXBURST))    n_beats = 8'(MAXBURST);
  end

  // Burst FSM: command acceptance, write strobes and read-beat issue
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    started_d   = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = address;
    iss_v       = 1'b0;
    iss_addr    = address;
    waitrequest = 1'b1;
    case (state_q)
      IDLE: begin
        waitrequest = !started_q || stall;
        if (!waitrequest) begin
          if (write) begin
            wr_en = 1'b1;
            if (n_beats > 8'd1) begin
              addr_d  = address + ADDR_ONE;
              rem_d   = n_beats - 8'd1;
              state_d = WRBURST;
            end
          end else if (read) begin
            iss_v = 1'b1;
            if (n_beats > 8'd1) begin
              addr_d  = address + ADDR_ONE;
              rem_d   = n_beats - 8'd1;
              state_d = RDBURST;
            end
          end
        end
      end
      WRBURST: begin
        waitrequest = stall;
        if (write && !stall) begin
          wr_en   = 1'b1;
          wr_addr = addr_q;
          addr_d  = addr_q + ADDR_ONE;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = IDLE;
        end
      end
      RDBURST: begin
        iss_v    = 1'b1;
        iss_addr = addr_q;
        addr_d   = addr_q + ADDR_ONE;
        rem_d    = rem_q - 8'd1;
        if (rem_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte-lane merge of the incoming write into the addressed word
  always_comb begin
    wr_word = '0;
    for (int i = 0; i < NBDATABYTES; i++) begin
      wr_word[8*i +: 8] = be_merge(mem_q[wr_addr][8*i +: 8], writedata[8*i +: 8], byteenable[i]);
    end
  end

  // FSM and burst counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      started_q <= started_d;
    end
  end

  // Word memory, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  avalon_resp_pipe #(
    .DW  (DW),
    .LAT (READLATENCY)
  ) u_pipe (
    .clk           (clk),
    .rst_n         (rst),
    .iss_valid     (iss_v),
    .iss_data      (mem_q[iss_addr]),
    .readdatavalid (readdatavalid),
    .readdata      (readdata)
  );

endmodule

// File: tb/tb_avalon_responder.sv
// tb/tb_avalon_responder.sv - directed self-checking bench for avalon_responder
module tb_avalon_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  address = '0;
  logic [1:0]  byteenable = '0;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        waitrequest;
  logic        readdatavalid;
  logic [7:0]  burstcount = '0;
  logic        beginbursttransfer = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int a, a0, a1, a2, a3;

  logic        rdv_at [0:4095];
  logic [15:0] rd_at  [0:4095];

  avalon_responder dut (
    .clk                (clk),
    .rst                (rst),
    .address            (address),
    .byteenable         (byteenable),
    .writedata          (writedata),
    .readdata           (readdata),
    .read               (read),
    .write              (write),
    .waitrequest        (waitrequest),
    .readdatavalid      (readdatavalid),
    .burstcount         (burstcount),
    .beginbursttransfer (beginbursttransfer)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rdv_at[cyc] = readdatavalid;
    rd_at[cyc]  = readdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic rd, input logic wr, input logic [7:0] ad,
                     input logic [15:0] d, input logic [1:0] be, input logic [7:0] bc,
                     output int acc);
    read = rd; write = wr; address = ad; writedata = d; byteenable = be;
    burstcount = bc; beginbursttransfer = 1'b1;
    for (int g = 0; g < 64 && waitrequest; g++) step();
    chk("accept", waitrequest, 1'b0);
    acc = cyc;
    step();
    read = 1'b0; write = 1'b0; beginbursttransfer = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int c, input logic [15:0] exp);
    chk({tag, "_rdv"}, rdv_at[c], 1'b1);
    chk({tag, "_data"}, rd_at[c], exp);
  endtask

  function automatic int count_rdv(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (rdv_at[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    // reset state
    step(); step(); step();
    chk("rst_wait", waitrequest, 1'b1);
    chk("rst_rdv", readdatavalid, 1'b0);
    chk("rst_rdata", readdata, 16'h0000);
    rst = 1'b1;
    step();
    chk("wait_after_rel", waitrequest, 1'b0);

    // single write then read, latency 2
    cmd(1'b0, 1'b1, 8'h10, 16'hBEEF, 2'b11, 8'd1, a);
    cmd(1'b1, 1'b0, 8'h10, 16'h0000, 2'b00, 8'd1, a);
    step(); step(); step();
    chk("t1_early", rdv_at[a+1], 1'b0);
    chk_rd("t1", a + 2, 16'hBEEF);
    chk("t1_late", rdv_at[a+3], 1'b0);

    // byte-lane write
    cmd(1'b0, 1'b1, 8'h20, 16'h1234, 2'b11, 8'd1, a);
    cmd(1'b0, 1'b1, 8'h20, 16'hAB00, 2'b10, 8'd1, a);
    cmd(1'b1, 1'b0, 8'h20, 16'h0000, 2'b00, 8'd1, a);
    step(); step(); step();
    chk_rd("be", a + 2, 16'hAB34);

    // write burst of 4 at 0xFE with a gap, wraps to 0x00
    cmd(1'b0, 1'b1, 8'hFE, 16'h0001, 2'b11, 8'd4, a);
    write = 1'b1; writedata = 16'h0002; address = 8'h55; burstcount = 8'd9;
    chk("wrb_wait", waitrequest, 1'b0);
    step();
    write = 1'b0; read = 1'b1;
    step();
    read = 1'b0; write = 1'b1; writedata = 16'h0003;
    step();
    writedata = 16'h0004;
    step();
    write = 1'b0;
    cmd(1'b1, 1'b0, 8'hFE, 16'h0, 2'b00, 8'd1, a0);
    cmd(1'b1, 1'b0, 8'hFF, 16'h0, 2'b00, 8'd1, a1);
    cmd(1'b1, 1'b0, 8'h00, 16'h0, 2'b00, 8'd1, a2);
    cmd(1'b1, 1'b0, 8'h01, 16'h0, 2'b00, 8'd1, a3);
    step(); step(); step();
    chk_rd("wrap0", a0 + 2, 16'h0001);
    chk_rd("wrap1", a1 + 2, 16'h0002);
    chk_rd("wrap2", a2 + 2, 16'h0003);
    chk_rd("wrap3", a3 + 2, 16'h0004);

    // read burst of 4 at 0xFE
    cmd(1'b1, 1'b0, 8'hFE, 16'h0, 2'b00, 8'd4, a);
    chk("rdb_wait1", waitrequest, 1'b1);
    step();
    chk("rdb_wait2", waitrequest, 1'b1);
    step();
    chk("rdb_wait3", waitrequest, 1'b1);
    step();
    chk("rdb_wait_end", waitrequest, 1'b0);
    step(); step(); step();
    chk_rd("rdb0", a + 2, 16'h0001);
    chk_rd("rdb1", a + 3, 16'h0002);
    chk_rd("rdb2", a + 4, 16'h0003);
    chk_rd("rdb3", a + 5, 16'h0004);
    chk("rdb_after", rdv_at[a+6], 1'b0);

    // three back-to-back single reads
    cmd(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, 8'd1, a0);
    cmd(1'b1, 1'b0, 8'h20, 16'h0, 2'b00, 8'd1, a1);
    cmd(1'b1, 1'b0, 8'hFE, 16'h0, 2'b00, 8'd1, a2);
    step(); step(); step();
    chk("b2b_cons", a2 - a0, 2);
    chk_rd("b2b0", a0 + 2, 16'hBEEF);
    chk_rd("b2b1", a0 + 3, 16'hAB34);
    chk_rd("b2b2", a0 + 4, 16'h0001);

    // read and write together: write wins, read dropped
    cmd(1'b1, 1'b1, 8'h30, 16'h5555, 2'b11, 8'd1, a);
    step(); step(); step();
    chk("both_no_rdv", count_rdv(a + 1, a + 3), 0);
    // burstcount 0 reads a single beat
    cmd(1'b1, 1'b0, 8'h30, 16'h0, 2'b00, 8'd0, a);
    chk("bc0_wait", waitrequest, 1'b0);
    step(); step(); step();
    chk_rd("bc0", a + 2, 16'h5555);
    chk("bc0_single", rdv_at[a+3], 1'b0);

    // oversize burst clamps to 16 beats
    cmd(1'b1, 1'b0, 8'h00, 16'h0, 2'b00, 8'd200, a);
    for (int g = 0; g < 300 && waitrequest; g++) step();
    chk("clamp_done", waitrequest, 1'b0);
    while (cyc < a + 22) step();
    chk("clamp_beats", count_rdv(a + 1, a + 21), 16);
    chk_rd("clamp_first", a + 2, 16'h0003);

    // reset during a burst-8 read
    cmd(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, 8'd8, a);
    rst = 1'b0;
    #1;
    chk("mid_rst_wait", waitrequest, 1'b1);
    chk("mid_rst_rdv", readdatavalid, 1'b0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("mid_rst_none", count_rdv(a + 1, cyc - 1), 0);
    cmd(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, 8'd1, a);
    step(); step(); step();
    chk_rd("mid_rst_mem", a + 2, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
